// File: rtl/alu_pkg.sv
// ALU / arbiter shared package.
// Holds the opcode enumeration, the highest legal opcode, datapath widths,
// the arbiter FSM state type and an opcode legality helper.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [OP_W-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        NOR = 4'd3,
        XOR = 4'd4,
        SHR = 4'd5,
        SHL = 4'd6,
        EQ  = 4'd7,
        NE  = 4'd8,
        GT  = 4'd9,
        LT  = 4'd10
    } alu_op_e;

    // Highest legal opcode; everything above is reported as an error.
    localparam int unsigned OP_LAST = 10;

    typedef enum logic {
        StIdle,
        StExec
    } arb_state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return 32'(op) <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter.
// Two requesters (A, B), each with valid/op/a/b in and ready out, plus one
// shared registered response channel (valid pulse, id, result, flags, err).
// slave  : seen from the arbiter (requests in, ready/response out)
// master : seen from the requesters / response consumer
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              ReqA_valid;
    logic [OP_W-1:0]   ReqA_op;
    logic [DATA_W-1:0] ReqA_a;
    logic [DATA_W-1:0] ReqA_b;
    logic              ReqA_ready;

    logic              ReqB_valid;
    logic [OP_W-1:0]   ReqB_op;
    logic [DATA_W-1:0] ReqB_a;
    logic [DATA_W-1:0] ReqB_b;
    logic              ReqB_ready;

    logic              Rsp_valid;
    logic              Rsp_id;
    logic [DATA_W-1:0] Rsp_out;
    logic              Rsp_zero;
    logic              Rsp_parity;
    logic              Rsp_odd;
    logic              Rsp_err;

    modport slave (
        input  ReqA_valid, ReqA_op, ReqA_a, ReqA_b,
        input  ReqB_valid, ReqB_op, ReqB_a, ReqB_b,
        output ReqA_ready, ReqB_ready,
        output Rsp_valid, Rsp_id, Rsp_out, Rsp_zero, Rsp_parity, Rsp_odd, Rsp_err
    );

    modport master (
        output ReqA_valid, ReqA_op, ReqA_a, ReqA_b,
        output ReqB_valid, ReqB_op, ReqB_a, ReqB_b,
        input  ReqA_ready, ReqB_ready,
        input  Rsp_valid, Rsp_id, Rsp_out, Rsp_zero, Rsp_parity, Rsp_odd, Rsp_err
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU.
// Ports:
//   op     in  4  opcode (alu_op_e encoding)
//   a, b   in  8  operands
//   sc_in  in  1  carry-in for ADD, borrow-in for SUB, fill bit for shifts
//   out    out 8  result (0 for illegal opcodes)
//   zero   out 1  result is zero (0 for illegal opcodes)
//   parity out 1  XOR of all result bits
//   odd    out 1  result LSB
//   err    out 1  opcode above OP_LAST
// Shifts move by b[2:0]; arithmetic wraps at 8 bits.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sc_in,
    output logic [DATA_W-1:0] out,
    output logic              zero,
    output logic              parity,
    output logic              odd,
    output logic              err
);

    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sc_ext;
    logic [2:0]        shamt;
    logic              illegal;

    assign sc_ext = {{(DATA_W-1){1'b0}}, sc_in};
    assign shamt  = b[2:0];

    always_comb begin
        res     = '0;
        illegal = !op_is_legal(op);
        case (alu_op_e'(op))
            ADD: res = a + b + sc_ext;
            SUB: res = a - b - sc_ext;
            AND: res = a & b;
            NOR: res = ~(a | b);
            XOR: res = a ^ b;
            // Vacated bit positions take the value of sc_in.
            SHR: res = (a >> shamt) | (sc_in ? ~(8'hFF >> shamt) : 8'h00);
            SHL: res = (a << shamt) | (sc_in ? ~(8'hFF << shamt) : 8'h00);
            EQ:  res = {7'd0, a == b};
            NE:  res = {7'd0, a != b};
            GT:  res = {7'd0, a > b};
            LT:  res = {7'd0, a < b};
            default: res = '0;
        endcase
    end

    // res is already zero for illegal opcodes; only zero needs masking.
    assign out    = res;
    assign zero   = !illegal && (res == '0);
    assign parity = ^res;
    assign odd    = res[0];
    assign err    = illegal;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Ports:
//   Clk    in  clock, all state on the rising edge
//   Reset  in  synchronous active-high reset
//   bus    slave modport of alu_arbiter_if (requests A/B, registered response)
// Parameter RR_INIT selects the requester holding priority after reset
// (0 = A, 1 = B).
// A handshake in StIdle captures the request and moves to StExec; the ALU
// works from the captured registers only, and at the end of StExec its
// result is registered onto the response channel as a one-cycle pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    alu_arbiter_if.slave bus
);

    arb_state_e        state_q;
    logic              ptr_q;      // 1 = B has priority when both are valid
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;

    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_out_q;
    logic              rsp_zero_q;
    logic              rsp_parity_q;
    logic              rsp_odd_q;
    logic              rsp_err_q;

    logic              grant_a;
    logic              grant_b;
    logic              handshake;

    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              alu_parity;
    logic              alu_odd;
    logic              alu_err;

    // Grants already include valid, so a grant is a handshake.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == StIdle && !Reset) begin
            if (bus.ReqA_valid && bus.ReqB_valid) begin
                grant_a = !ptr_q;
                grant_b = ptr_q;
            end else begin
                grant_a = bus.ReqA_valid;
                grant_b = bus.ReqB_valid;
            end
        end
    end

    assign handshake      = grant_a | grant_b;
    assign bus.ReqA_ready = grant_a;
    assign bus.ReqB_ready = grant_b;

    alu_arbiter_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .sc_in  (1'b0),
        .out    (alu_out),
        .zero   (alu_zero),
        .parity (alu_parity),
        .odd    (alu_odd),
        .err    (alu_err)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            ptr_q        <= (RR_INIT != 0);
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_parity_q <= 1'b0;
            rsp_odd_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        op_q    <= grant_b ? bus.ReqB_op : bus.ReqA_op;
                        a_q     <= grant_b ? bus.ReqB_a  : bus.ReqA_a;
                        b_q     <= grant_b ? bus.ReqB_b  : bus.ReqA_b;
                        id_q    <= grant_b;
                        // Priority passes to whoever was not served.
                        ptr_q   <= !grant_b;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_out_q    <= alu_out;
                    rsp_zero_q   <= alu_zero;
                    rsp_parity_q <= alu_parity;
                    rsp_odd_q    <= alu_odd;
                    rsp_err_q    <= alu_err;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign bus.Rsp_valid  = rsp_valid_q;
    assign bus.Rsp_id     = rsp_id_q;
    assign bus.Rsp_out    = rsp_out_q;
    assign bus.Rsp_zero   = rsp_zero_q;
    assign bus.Rsp_parity = rsp_parity_q;
    assign bus.Rsp_odd    = rsp_odd_q;
    assign bus.Rsp_err    = rsp_err_q;

endmodule
